// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state enums shared by the ALU sequencer and its strobe decoder.
package alu_seq_pkg;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SHL, OP_SHR, OP_ILLEGAL
   } op_e;
   typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPTURE, RESP} state_e;
   localparam int EXEC_CW = 4;
endpackage

// File: rtl/alu_strobe_decode.sv
// alu_strobe_decode: opcode plus enable to a one-hot ALU strobe vector (bit 0 add .. bit 6 shr).
module alu_strobe_decode
   import alu_seq_pkg::*;
(
   input  op_e        op,
   input  logic       en,
   output logic [6:0] strobe
);
   always_comb strobe = (en && op != OP_ILLEGAL) ? 7'b1 << op : 7'b0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation, sequences load/strobe/oe on the ALU ports,
// captures the result and returns it over a valid/ready handshake.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] op_fi,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] fi,
   output logic             wa,
   output logic             wb,
   output logic             alu_add,
   output logic             alu_sub,
   output logic             alu_and,
   output logic             alu_or,
   output logic             alu_not,
   output logic             alu_shl,
   output logic             alu_shr,
   output logic             oe,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] fo,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [WIDTH-1:0] res_flags,
   output logic             res_err
);
   state_e             state;
   op_e                op_q;
   logic [EXEC_CW-1:0] cnt;
   logic [6:0]         strobe;

   // Strobes follow the registered oe, so they are active exactly in EXEC and CAPTURE.
   alu_strobe_decode u_dec (.op(op_q), .en(oe), .strobe(strobe));
   assign {alu_shr, alu_shl, alu_not, alu_or, alu_and, alu_sub, alu_add} = strobe;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         op_q      <= OP_ADD;
         cnt       <= '0;
         a         <= '0;
         b         <= '0;
         fi        <= '0;
         wa        <= 1'b0;
         wb        <= 1'b0;
         oe        <= 1'b0;
         op_ready  <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_flags <= '0;
         res_err   <= 1'b0;
      end else
         case (state)
            IDLE:
               if (op_valid) begin
                  op_q     <= op_e'(op_code);
                  op_ready <= 1'b0;
                  if (op_e'(op_code) == OP_ILLEGAL) begin
                     state     <= RESP;
                     res_valid <= 1'b1;
                     res_err   <= 1'b1;
                     res_data  <= '0;
                     res_flags <= '0;
                  end else begin
                     state <= LOAD;
                     a     <= op_a;
                     b     <= op_b;
                     fi    <= op_fi;
                     wa    <= 1'b1;
                     wb    <= op_e'(op_code) != OP_NOT;
                  end
               end
            LOAD: begin
               state <= EXEC;
               wa    <= 1'b0;
               wb    <= 1'b0;
               oe    <= 1'b1;
               cnt   <= EXEC_CW'(EXEC_CYCLES - 1);
            end
            EXEC:
               if (cnt == '0) state <= CAPTURE;
               else cnt <= cnt - EXEC_CW'(1);
            CAPTURE: begin
               state     <= RESP;
               oe        <= 1'b0;
               res_valid <= 1'b1;
               res_data  <= d;
               res_flags <= fo;
               res_err   <= 1'b0;
            end
            RESP:
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  op_ready  <= 1'b1;
                  a         <= '0;
                  b         <= '0;
                  fi        <= '0;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed tests of alu_sequencer against a small behavioural ALU stand-in.
module tb_alu_sequencer;
   localparam int W  = 8;
   localparam int EX = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic op_valid = 1'b0, op_ready, res_ready = 1'b0, res_valid, res_err;
   logic [2:0] op_code = 3'd0;
   logic [W-1:0] op_a = '0, op_b = '0, op_fi = '0;
   logic [W-1:0] a, b, fi, d, fo, res_data, res_flags;
   logic wa, wb, oe, alu_add, alu_sub, alu_and, alu_or, alu_not, alu_shl, alu_shr;
   logic [W-1:0] ra = '0, rb = '0;
   logic [6:0] st;
   int errors = 0, checks = 0;
   int wb_cnt = 0, ctrl_cnt = 0, bad_cnt = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(W), .EXEC_CYCLES(EX)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .op_fi(op_fi), .a(a), .b(b), .fi(fi), .wa(wa), .wb(wb),
      .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and), .alu_or(alu_or),
      .alu_not(alu_not), .alu_shl(alu_shl), .alu_shr(alu_shr), .oe(oe), .d(d), .fo(fo),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_flags(res_flags), .res_err(res_err)
   );

   // ALU stand-in: operand registers loaded by wa/wb, result and flags driven while oe is high.
   assign st = {alu_shr, alu_shl, alu_not, alu_or, alu_and, alu_sub, alu_add};
   always @(posedge clk) begin
      if (wa) ra <= a;
      if (wb) rb <= b;
   end
   always_comb begin
      d  = !oe ? 8'h00 : alu_add ? ra + rb : alu_sub ? ra - rb : alu_and ? ra & rb :
           alu_or ? ra | rb : alu_not ? ~ra : alu_shl ? ra << 1 : alu_shr ? ra >> 1 : 8'h00;
      fo = oe ? fi ^ 8'h5A : 8'h00;
   end

   always @(negedge clk) begin
      if (wb) wb_cnt <= wb_cnt + 1;
      if (wa | wb | oe | (|st)) ctrl_cnt <= ctrl_cnt + 1;
      if (!$onehot0(st) || (oe && !$onehot(st)) || ((oe | (|st)) && (wa | wb)))
         bad_cnt <= bad_cnt + 1;
   end

   task automatic test_reset();
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
      checks++; if ({res_valid, oe, wa, wb, st, res_err} !== 12'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {res_valid, oe, wa, wb, st, res_err}); end
      checks++; if ({a, b, fi, res_data, res_flags} !== 40'h0) begin errors++; $display("FAIL reset_data got %h want 0", {a, b, fi, res_data, res_flags}); end
   endtask

   task automatic do_op(input string nm, input logic [2:0] code, input logic [7:0] av, bv, fv,
                        input logic [7:0] ed, ef, input logic ee, input int elat, input int ewb, input int ectrl);
      int n, wb0, ctrl0, bad0;
      @(negedge clk);
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL %s op_ready got %b want 1", nm, op_ready); end
      op_valid = 1'b1; op_code = code; op_a = av; op_b = bv; op_fi = fv;
      wb0 = wb_cnt; ctrl0 = ctrl_cnt; bad0 = bad_cnt;
      @(posedge clk); #1 op_valid = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (res_valid !== 1'b1 && n < 40);
      checks++; if (n !== elat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, n, elat); end
      checks++; if (res_data !== ed) begin errors++; $display("FAIL %s res_data got %h want %h", nm, res_data, ed); end
      checks++; if (res_flags !== ef) begin errors++; $display("FAIL %s res_flags got %h want %h", nm, res_flags, ef); end
      checks++; if (res_err !== ee) begin errors++; $display("FAIL %s res_err got %b want %b", nm, res_err, ee); end
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL %s op_ready_resp got %b want 0", nm, op_ready); end
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      checks++; if ({res_valid, op_ready} !== 2'b01) begin errors++; $display("FAIL %s after_hs valid/ready got %b want 01", nm, {res_valid, op_ready}); end
      checks++; if ({a, b, fi} !== 24'h0) begin errors++; $display("FAIL %s idle_operands got %h want 0", nm, {a, b, fi}); end
      checks++; if (res_data !== ed) begin errors++; $display("FAIL %s retained got %h want %h", nm, res_data, ed); end
      checks++; if (wb_cnt - wb0 !== ewb) begin errors++; $display("FAIL %s wb_cycles got %0d want %0d", nm, wb_cnt - wb0, ewb); end
      checks++; if (ctrl_cnt - ctrl0 !== ectrl) begin errors++; $display("FAIL %s ctrl_cycles got %0d want %0d", nm, ctrl_cnt - ctrl0, ectrl); end
      checks++; if (bad_cnt !== bad0) begin errors++; $display("FAIL %s strobe_invariant got %0d want %0d", nm, bad_cnt - bad0, 0); end
   endtask

   task automatic test_ops();
      do_op("add", 3'd0, 8'd100, 8'd1, 8'h00, 8'd101, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
      do_op("sub", 3'd1, 8'd100, 8'd1, 8'h01, 8'd99, 8'h5B, 1'b0, EX + 2, 1, EX + 2);
      do_op("and", 3'd2, 8'hF0, 8'h3C, 8'h00, 8'h30, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
      do_op("or",  3'd3, 8'hF0, 8'h0F, 8'hFF, 8'hFF, 8'hA5, 1'b0, EX + 2, 1, EX + 2);
      do_op("not", 3'd4, 8'h0F, 8'h55, 8'h00, 8'hF0, 8'h5A, 1'b0, EX + 2, 0, EX + 2);
      do_op("shl", 3'd5, 8'h81, 8'h00, 8'h00, 8'h02, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
      do_op("shr", 3'd6, 8'h81, 8'h00, 8'h00, 8'h40, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
   endtask

   task automatic test_illegal();
      do_op("illegal", 3'd7, 8'd12, 8'd34, 8'd56, 8'h00, 8'h00, 1'b1, 1, 0, 0);
      do_op("after_illegal", 3'd0, 8'd7, 8'd8, 8'h00, 8'd15, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
   endtask

   task automatic test_stall();
      int n, bad;
      @(negedge clk);
      op_valid = 1'b1; op_code = 3'd0; op_a = 8'd3; op_b = 8'd4; op_fi = 8'h00;
      @(posedge clk); #1 op_code = 3'd1; op_a = 8'd9;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (res_valid !== 1'b1 && n < 40);
      checks++; if (n !== EX + 2) begin errors++; $display("FAIL stall latency got %0d want %0d", n, EX + 2); end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if ({res_valid, op_ready, res_data} !== {2'b10, 8'd7}) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall hold got %0d bad cycles want 0 (data %h)", bad, res_data); end
      op_valid = 1'b0; res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if ({res_valid, oe, wa, op_ready} !== 4'b0001) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall no_queue got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_reset_exec();
      int bad;
      @(negedge clk);
      op_valid = 1'b1; op_code = 3'd0; op_a = 8'd5; op_b = 8'd6; op_fi = 8'h00;
      @(posedge clk); #1 op_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({oe, alu_add} !== 2'b11) begin errors++; $display("FAIL rst_exec in_exec got %b want 11", {oe, alu_add}); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({oe, wa, wb, st, res_valid, op_ready} !== 12'h001) begin errors++; $display("FAIL rst_exec ctrl got %h want 001", {oe, wa, wb, st, res_valid, op_ready}); end
      checks++; if ({a, b, fi} !== 24'h0) begin errors++; $display("FAIL rst_exec operands got %h want 0", {a, b, fi}); end
      @(negedge clk); rst = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || op_ready !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rst_exec stray_result got %0d bad cycles want 0", bad); end
      do_op("after_rst", 3'd3, 8'h0A, 8'h50, 8'h00, 8'h5A, 8'h5A, 1'b0, EX + 2, 1, EX + 2);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b1;
      test_ops();
      test_illegal();
      test_stall();
      test_reset_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1);
   end
endmodule
